nf10_arp_filter: RTL and testbench

NF10_ARP_FILTER -- requirements
Module: nf10_arp_filter

---
 rtl/nf10_arp_filter.sv | 186 ++++++++++++++++++
 tb/tb_nf10_arp_filter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_arp_filter.sv
// ARP request filter: ARP requests addressed to C_IP_ADDR go to m0, all other
// traffic to m1. Beat0 is held until beat1 can be inspected, then streamed.
module nf10_arp_filter #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [31:0] C_IP_ADDR            = 32'hC0A80164
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m0_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m0_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m0_axis_tuser,
  output logic                              m0_axis_tvalid,
  output logic                              m0_axis_tlast,
  input  logic                              m0_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m1_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m1_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m1_axis_tuser,
  output logic                              m1_axis_tvalid,
  output logic                              m1_axis_tlast,
  input  logic                              m1_axis_tready,

  output logic [31:0]                       arp_pkt_count,
  output logic [31:0]                       other_pkt_count
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, HOLD, SEND0, PASS} state_t;

  state_t                            state, state_nxt;

  logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data;
  logic [STRB_W-1:0]                 hold_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   hold_user;
  logic                              hold_last;
  logic                              dest_m0, dest_m0_nxt;

  logic                              load_hold;
  logic                              pkt_done;
  logic                              in_ready;
  logic                              out_valid;
  logic                              out_last;
  logic                              dest_ready;
  logic                              arp_match;

  logic [C_S_AXIS_DATA_WIDTH-1:0]    out_data;
  logic [STRB_W-1:0]                 out_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   out_user;

  // Byte n sits at tdata[8n+7:8n]; fields are big-endian across ascending bytes.
  assign arp_match = (hold_data[8*12 +: 8]    == 8'h08)            &&
                     (hold_data[8*13 +: 8]    == 8'h06)            &&
                     (hold_data[8*20 +: 8]    == 8'h00)            &&
                     (hold_data[8*21 +: 8]    == 8'h01)            &&
                     (s_axis_tdata[8*6 +: 8]  == C_IP_ADDR[31:24]) &&
                     (s_axis_tdata[8*7 +: 8]  == C_IP_ADDR[23:16]) &&
                     (s_axis_tdata[8*8 +: 8]  == C_IP_ADDR[15:8])  &&
                     (s_axis_tdata[8*9 +: 8]  == C_IP_ADDR[7:0]);

  assign dest_ready = dest_m0 ? m0_axis_tready : m1_axis_tready;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, regardless of block ordering.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    dest_m0_nxt = dest_m0;
    load_hold   = 1'b0;
    pkt_done    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (s_axis_tvalid) begin
          load_hold   = 1'b1;
          dest_m0_nxt = 1'b0;
          state_nxt   = s_axis_tlast ? SEND0 : HOLD;
        end
      end

      // Beat1 is only inspected here, not consumed; PASS takes it later.
      HOLD: begin
        if (s_axis_tvalid) begin
          dest_m0_nxt = arp_match;
          state_nxt   = SEND0;
        end
      end

      SEND0: begin
        out_valid = 1'b1;
        out_last  = hold_last;
        if (dest_ready) begin
          pkt_done  = hold_last;
          state_nxt = hold_last ? IDLE : PASS;
        end
      end

      PASS: begin
        in_ready  = dest_ready;
        out_valid = s_axis_tvalid;
        out_last  = s_axis_tlast;
        if (s_axis_tvalid && dest_ready && s_axis_tlast) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the hold buffer is a single register set, not a memory array, so it
  // is cleared on reset like any other flop.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      hold_data <= '0;
      hold_strb <= '0;
      hold_user <= '0;
      hold_last <= 1'b0;
      dest_m0   <= 1'b0;
    end else begin
      if (load_hold) begin
        hold_data <= s_axis_tdata;
        hold_strb <= s_axis_tstrb;
        hold_user <= s_axis_tuser;
        hold_last <= s_axis_tlast;
      end
      dest_m0 <= dest_m0_nxt;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      arp_pkt_count   <= '0;
      other_pkt_count <= '0;
    end else if (pkt_done) begin
      if (dest_m0) begin
        arp_pkt_count <= arp_pkt_count + 32'd1;
      end else begin
        other_pkt_count <= other_pkt_count + 32'd1;
      end
    end
  end

  assign out_data = (state == PASS) ? s_axis_tdata : hold_data;
  assign out_strb = (state == PASS) ? s_axis_tstrb : hold_strb;
  assign out_user = (state == PASS) ? s_axis_tuser : hold_user;

  assign m0_axis_tdata = out_data;
  assign m0_axis_tstrb = out_strb;
  assign m0_axis_tuser = out_user;
  assign m1_axis_tdata = out_data;
  assign m1_axis_tstrb = out_strb;
  assign m1_axis_tuser = out_user;

  // Handshake outputs are forced quiet while reset is asserted, since the
  // state register may not yet hold a defined value.
  assign s_axis_tready  = in_ready & axi_resetn;
  assign m0_axis_tvalid = out_valid &  dest_m0 & axi_resetn;
  assign m1_axis_tvalid = out_valid & ~dest_m0 & axi_resetn;
  assign m0_axis_tlast  = out_last  &  dest_m0 & axi_resetn;
  assign m1_axis_tlast  = out_last  & ~dest_m0 & axi_resetn;

endmodule

// File: tb/tb_nf10_arp_filter.sv
// Self-checking bench for nf10_arp_filter: directed vector table, hand-written
// timing sequences, and a randomized packet stream against a packet-level model.
module tb_nf10_arp_filter;

  localparam logic [31:0]  IP        = 32'hC0A80164;
  localparam logic [255:0] B0_ARP    = 256'h0101A8C066554433221101000506070801020608665544332211FFFFFFFFFFFF;
  localparam logic [255:0] B0_IPV4   = 256'h0101A8C066554433221101000506070801020008665544332211FFFFFFFFFFFF;
  localparam logic [255:0] B0_SWAP   = 256'h0101A8C066554433221101000506070801020806665544332211FFFFFFFFFFFF;
  localparam logic [255:0] B0_REPLY  = 256'h0101A8C066554433221102000506070801020608665544332211FFFFFFFFFFFF;
  localparam logic [255:0] B0_OPHI   = 256'h0101A8C066554433221101010506070801020608665544332211FFFFFFFFFFFF;
  localparam logic [255:0] B1_ARP    = 256'h6401A8C0000000000000;
  localparam logic [255:0] B1_IP65   = 256'h6501A8C0000000000000;
  localparam logic [255:0] B1_IP00   = 256'h6401A800000000000000;
  localparam logic [127:0] U_REQ     = 128'h0004AAAA;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    string        name;
    logic [255:0] b0;
    logic [255:0] b1;
    int           nbeats;
    bit           exp_m0;
  } vec_t;

  logic         axi_aclk;
  logic         axi_resetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [255:0] m0_axis_tdata;
  logic [31:0]  m0_axis_tstrb;
  logic [127:0] m0_axis_tuser;
  logic         m0_axis_tvalid;
  logic         m0_axis_tlast;
  logic         m0_axis_tready;
  logic [255:0] m1_axis_tdata;
  logic [31:0]  m1_axis_tstrb;
  logic [127:0] m1_axis_tuser;
  logic         m1_axis_tvalid;
  logic         m1_axis_tlast;
  logic         m1_axis_tready;
  logic [31:0]  arp_pkt_count;
  logic [31:0]  other_pkt_count;

  nf10_arp_filter #(
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_TUSER_WIDTH (128),
    .C_IP_ADDR            (IP)
  ) dut (
    .axi_aclk        (axi_aclk),
    .axi_resetn      (axi_resetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tstrb    (s_axis_tstrb),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m0_axis_tdata   (m0_axis_tdata),
    .m0_axis_tstrb   (m0_axis_tstrb),
    .m0_axis_tuser   (m0_axis_tuser),
    .m0_axis_tvalid  (m0_axis_tvalid),
    .m0_axis_tlast   (m0_axis_tlast),
    .m0_axis_tready  (m0_axis_tready),
    .m1_axis_tdata   (m1_axis_tdata),
    .m1_axis_tstrb   (m1_axis_tstrb),
    .m1_axis_tuser   (m1_axis_tuser),
    .m1_axis_tvalid  (m1_axis_tvalid),
    .m1_axis_tlast   (m1_axis_tlast),
    .m1_axis_tready  (m1_axis_tready),
    .arp_pkt_count   (arp_pkt_count),
    .other_pkt_count (other_pkt_count)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       src_q[$];
  beat_t       m0_got[$], m1_got[$], m0_exp[$], m1_exp[$];
  bit          got_order[$], exp_order[$];
  logic [31:0] exp_arp = 0;
  logic [31:0] exp_other = 0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    check(name, 256'(got), 256'(exp));
  endtask

  function automatic logic [255:0] meta(input beat_t b);
    return {95'd0, b.user, b.strb, b.last};
  endfunction

  function automatic logic [7:0] byte_of(input logic [255:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  // Packet-level rule: EtherType 0806, opcode 0001, target IP in beat1 bytes 6-9.
  function automatic bit model_match(input beat_t p[$]);
    if (p.size() < 2) return 1'b0;
    return byte_of(p[0].data, 12) == 8'h08 && byte_of(p[0].data, 13) == 8'h06 &&
           byte_of(p[0].data, 20) == 8'h00 && byte_of(p[0].data, 21) == 8'h01 &&
           {byte_of(p[1].data, 6), byte_of(p[1].data, 7),
            byte_of(p[1].data, 8), byte_of(p[1].data, 9)} == IP;
  endfunction

  // Output monitor: sampled mid-cycle, a valid&ready pair is the transfer at the next edge.
  logic  p0_stall = 1'b0, p1_stall = 1'b0;
  beat_t p0_beat, p1_beat;
  always @(negedge axi_aclk) begin
    beat_t c0, c1;
    c0 = '{data: m0_axis_tdata, strb: m0_axis_tstrb, user: m0_axis_tuser, last: m0_axis_tlast};
    c1 = '{data: m1_axis_tdata, strb: m1_axis_tstrb, user: m1_axis_tuser, last: m1_axis_tlast};
    if (p0_stall && axi_resetn) begin
      check_int("m0_stall_valid", int'(m0_axis_tvalid), 1);
      check("m0_stall_data", c0.data, p0_beat.data);
      check("m0_stall_meta", meta(c0), meta(p0_beat));
    end
    if (p1_stall && axi_resetn) begin
      check_int("m1_stall_valid", int'(m1_axis_tvalid), 1);
      check("m1_stall_data", c1.data, p1_beat.data);
      check("m1_stall_meta", meta(c1), meta(p1_beat));
    end
    if (m0_axis_tvalid && m1_axis_tvalid) check_int("both_valid", 1, 0);
    if (m0_axis_tvalid && m0_axis_tready) begin
      m0_got.push_back(c0);
      if (m0_axis_tlast) got_order.push_back(1'b1);
    end
    if (m1_axis_tvalid && m1_axis_tready) begin
      m1_got.push_back(c1);
      if (m1_axis_tlast) got_order.push_back(1'b0);
    end
    p0_stall <= m0_axis_tvalid && !m0_axis_tready && axi_resetn;
    p1_stall <= m1_axis_tvalid && !m1_axis_tready && axi_resetn;
    p0_beat  <= c0;
    p1_beat  <= c1;
  end

  task automatic next_cycle();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic drive(input logic [255:0] d, input logic [127:0] u, input logic l, input logic v);
    s_axis_tdata  = d;
    s_axis_tstrb  = '1;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = v;
  endtask

  function automatic beat_t mk(input logic [255:0] d, input logic [127:0] u, input logic l);
    return '{data: d, strb: 32'hFFFF_FFFF, user: u, last: l};
  endfunction

  task automatic clear_sb();
    m0_got.delete(); m1_got.delete(); m0_exp.delete(); m1_exp.delete();
    got_order.delete(); exp_order.delete();
  endtask

  task automatic send_pkt(input beat_t p[$], input bit to_m0);
    foreach (p[i]) begin
      src_q.push_back(p[i]);
      if (to_m0) m0_exp.push_back(p[i]);
      else       m1_exp.push_back(p[i]);
    end
    exp_order.push_back(to_m0);
    if (to_m0) exp_arp++;
    else       exp_other++;
  endtask

  // One clock of the randomized source/sink; valid is held until accepted.
  task automatic step(input int vld_pct, input int rdy_pct);
    bit acc;
    @(negedge axi_aclk);
    acc = s_axis_tvalid && s_axis_tready;
    next_cycle();
    if (acc) src_q.delete(0);
    m0_axis_tready = ($urandom_range(99) < rdy_pct);
    m1_axis_tready = ($urandom_range(99) < rdy_pct);
    if (s_axis_tvalid && !acc) begin
      // keep presenting the same beat
    end else if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      s_axis_tdata  = src_q[0].data;
      s_axis_tstrb  = src_q[0].strb;
      s_axis_tuser  = src_q[0].user;
      s_axis_tlast  = src_q[0].last;
      s_axis_tvalid = 1'b1;
    end else begin
      s_axis_tdata  = {8{$urandom}};
      s_axis_tlast  = 1'($urandom);
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int vld_pct, input int rdy_pct);
    int budget = 5000;
    while ((src_q.size() > 0 || m0_got.size() < m0_exp.size() || m1_got.size() < m1_exp.size())
           && budget > 0) begin
      step(vld_pct, rdy_pct);
      budget--;
    end
    check_int({name, "_timeout"}, int'(budget > 0), 1);
    repeat (3) step(vld_pct, 100);
    m0_axis_tready = 1'b1;
    m1_axis_tready = 1'b1;
  endtask

  task automatic check_queues(input string name);
    check_int({name, "_m0_beats"}, m0_got.size(), m0_exp.size());
    for (int i = 0; i < m0_got.size() && i < m0_exp.size(); i++) begin
      check({name, "_m0_data"}, m0_got[i].data, m0_exp[i].data);
      check({name, "_m0_meta"}, meta(m0_got[i]), meta(m0_exp[i]));
    end
    check_int({name, "_m1_beats"}, m1_got.size(), m1_exp.size());
    for (int i = 0; i < m1_got.size() && i < m1_exp.size(); i++) begin
      check({name, "_m1_data"}, m1_got[i].data, m1_exp[i].data);
      check({name, "_m1_meta"}, meta(m1_got[i]), meta(m1_exp[i]));
    end
    check_int({name, "_pkts"}, got_order.size(), exp_order.size());
    for (int i = 0; i < got_order.size() && i < exp_order.size(); i++)
      check_int({name, "_order"}, int'(got_order[i]), int'(exp_order[i]));
    check({name, "_arp_count"}, 256'(arp_pkt_count), 256'(exp_arp));
    check({name, "_other_count"}, 256'(other_pkt_count), 256'(exp_other));
    clear_sb();
  endtask

  task automatic reset_phase();
    axi_resetn = 1'b0;
    m0_axis_tready = 1'b1;
    m1_axis_tready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    next_cycle();
    @(negedge axi_aclk);
    check_int("rst_s_ready", int'(s_axis_tready), 0);
    check_int("rst_m0_valid", int'(m0_axis_tvalid), 0);
    check_int("rst_m1_valid", int'(m1_axis_tvalid), 0);
    check_int("rst_tlast", int'(m0_axis_tlast | m1_axis_tlast), 0);
    next_cycle();
    axi_resetn = 1'b1;
    @(negedge axi_aclk);
    check_int("post_rst_valid", int'(m0_axis_tvalid | m1_axis_tvalid), 0);
    check_int("post_rst_tlast", int'(m0_axis_tlast | m1_axis_tlast), 0);
    check("post_rst_arp_count", 256'(arp_pkt_count), 256'd0);
    check("post_rst_other_count", 256'(other_pkt_count), 256'd0);
    check_int("post_rst_s_ready", int'(s_axis_tready), 1);
    next_cycle();
  endtask

  // ARP request to our IP, exact cycle timing of the hold/send path.
  task automatic hand_arp_latency();
    clear_sb();
    drive(B0_ARP, U_REQ, 1'b0, 1'b1);
    @(negedge axi_aclk);
    check_int("lat_idle_ready", int'(s_axis_tready), 1);
    next_cycle();
    drive(B1_ARP, U_REQ, 1'b1, 1'b1);
    @(negedge axi_aclk);
    check_int("lat_hold_ready", int'(s_axis_tready), 0);
    check_int("lat_hold_no_out", int'(m0_axis_tvalid | m1_axis_tvalid), 0);
    next_cycle();
    @(negedge axi_aclk);
    check_int("lat_send0_valid", int'(m0_axis_tvalid), 1);
    check_int("lat_send0_ready", int'(s_axis_tready), 0);
    check("lat_send0_data", m0_axis_tdata, B0_ARP);
    check("lat_send0_user", 256'(m0_axis_tuser), 256'(U_REQ));
    check_int("lat_send0_last", int'(m0_axis_tlast), 0);
    next_cycle();
    @(negedge axi_aclk);
    check_int("lat_pass_ready", int'(s_axis_tready), 1);
    check("lat_pass_data", m0_axis_tdata, B1_ARP);
    check_int("lat_pass_last", int'(m0_axis_tlast), 1);
    next_cycle();
    drive('0, '0, 1'b0, 1'b0);
    m0_exp.push_back(mk(B0_ARP, U_REQ, 1'b0));
    m0_exp.push_back(mk(B1_ARP, U_REQ, 1'b1));
    exp_order.push_back(1'b1);
    exp_arp++;
    @(negedge axi_aclk);
    check_queues("arp_req");
    next_cycle();
  endtask

  // Single-beat packet, then the next packet's beat0 must be taken right away.
  task automatic hand_single_beat();
    clear_sb();
    drive(B0_ARP, 128'h11, 1'b1, 1'b1);
    @(negedge axi_aclk);
    check_int("sb_accept", int'(s_axis_tready), 1);
    next_cycle();
    drive(B0_ARP, 128'h22, 1'b0, 1'b1);
    @(negedge axi_aclk);
    check_int("sb_m1_valid", int'(m1_axis_tvalid), 1);
    check_int("sb_m1_last", int'(m1_axis_tlast), 1);
    check("sb_m1_data", m1_axis_tdata, B0_ARP);
    next_cycle();
    @(negedge axi_aclk);
    check_int("sb_no_stall", int'(s_axis_tready), 1);
    next_cycle();
    drive(B1_ARP, 128'h22, 1'b1, 1'b1);
    repeat (3) next_cycle();
    drive('0, '0, 1'b0, 1'b0);
    m1_exp.push_back(mk(B0_ARP, 128'h11, 1'b1));
    m0_exp.push_back(mk(B0_ARP, 128'h22, 1'b0));
    m0_exp.push_back(mk(B1_ARP, 128'h22, 1'b1));
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    exp_other++;
    exp_arp++;
    @(negedge axi_aclk);
    check_queues("single_beat");
    next_cycle();
  endtask

  task automatic hand_stall();
    clear_sb();
    m0_axis_tready = 1'b0;
    drive(B0_ARP, 128'h33, 1'b0, 1'b1);
    next_cycle();
    drive(B1_ARP, 128'h33, 1'b1, 1'b1);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge axi_aclk);
      check_int("stall_valid", int'(m0_axis_tvalid), 1);
      check("stall_data", m0_axis_tdata, B0_ARP);
      check_int("stall_s_ready", int'(s_axis_tready), 0);
      next_cycle();
    end
    m0_axis_tready = 1'b1;
    @(negedge axi_aclk);
    check("stall_release_data", m0_axis_tdata, B0_ARP);
    next_cycle();
    @(negedge axi_aclk);
    check("stall_beat1_data", m0_axis_tdata, B1_ARP);
    check_int("stall_beat1_ready", int'(s_axis_tready), 1);
    next_cycle();
    drive('0, '0, 1'b0, 1'b0);
    m0_exp.push_back(mk(B0_ARP, 128'h33, 1'b0));
    m0_exp.push_back(mk(B1_ARP, 128'h33, 1'b1));
    exp_order.push_back(1'b1);
    exp_arp++;
    @(negedge axi_aclk);
    check_queues("stall");
    next_cycle();
  endtask

  // Reset pulse while beat0 of an ARP request is held; nothing may leak out.
  task automatic hand_reset_in_hold();
    beat_t p[$];
    clear_sb();
    drive(B0_ARP, 128'h44, 1'b0, 1'b1);
    next_cycle();
    drive(B1_ARP, 128'h44, 1'b1, 1'b1);
    axi_resetn = 1'b0;
    @(negedge axi_aclk);
    check_int("hold_rst_s_ready", int'(s_axis_tready), 0);
    check_int("hold_rst_valid", int'(m0_axis_tvalid | m1_axis_tvalid), 0);
    next_cycle();
    axi_resetn = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    exp_arp   = 0;
    exp_other = 0;
    @(negedge axi_aclk);
    check_int("hold_rst_after_valid", int'(m0_axis_tvalid | m1_axis_tvalid), 0);
    check("hold_rst_arp_count", 256'(arp_pkt_count), 256'd0);
    check("hold_rst_other_count", 256'(other_pkt_count), 256'd0);
    next_cycle();
    p.push_back(mk(B0_ARP, 128'h55, 1'b0));
    p.push_back(mk(B1_ARP, 128'h55, 1'b1));
    send_pkt(p, 1'b1);
    drain("after_rst", 100, 100);
    check_queues("after_rst");
  endtask

  task automatic table_phase();
    for (int v = 0; v < $size(vecs); v++) begin
      beat_t p[$];
      for (int k = 0; k < vecs[v].nbeats; k++) begin
        logic [255:0] d;
        d = (k == 0) ? vecs[v].b0 : (k == 1) ? vecs[v].b1 : {8{32'hC0DE0000 + 32'(k)}};
        p.push_back(mk(d, U_REQ + 128'(v), k == vecs[v].nbeats - 1));
      end
      clear_sb();
      send_pkt(p, vecs[v].exp_m0);
      drain(vecs[v].name, 100, 100);
      check_queues(vecs[v].name);
    end
  endtask

  task automatic back_to_back();
    beat_t a[$], b[$];
    clear_sb();
    a.push_back(mk(B0_ARP, 128'h66, 1'b0));
    a.push_back(mk(B1_ARP, 128'h66, 1'b1));
    for (int k = 0; k < 4; k++)
      b.push_back(mk(k == 0 ? B0_IPV4 : {8{32'hBEEF0000 + 32'(k)}}, 128'h77, k == 3));
    send_pkt(a, 1'b1);
    send_pkt(b, 1'b0);
    send_pkt(a, 1'b1);
    drain("b2b", 100, 100);
    check_queues("b2b");
  endtask

  task automatic random_phase();
    clear_sb();
    for (int p = 0; p < 40; p++) begin
      beat_t        pkt[$];
      logic [255:0] d[5];
      int           n;
      int           kind;
      n    = $urandom_range(1, 5);
      kind = $urandom_range(0, 3);
      for (int k = 0; k < 5; k++) d[k] = {$urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom, $urandom};
      if (kind <= 1) begin
        d[0][8*12 +: 8] = 8'h08;  d[0][8*13 +: 8] = 8'h06;
        d[0][8*20 +: 8] = 8'h00;  d[0][8*21 +: 8] = 8'h01;
        d[1][8*6 +: 8]  = IP[31:24]; d[1][8*7 +: 8] = IP[23:16];
        d[1][8*8 +: 8]  = IP[15:8];  d[1][8*9 +: 8] = IP[7:0];
      end
      if (kind == 1) begin
        int          f;
        logic [7:0]  x;
        f = $urandom_range(0, 7);
        x = 8'($urandom_range(1, 255));
        case (f)
          0: d[0][8*12 +: 8] = d[0][8*12 +: 8] ^ x;
          1: d[0][8*13 +: 8] = d[0][8*13 +: 8] ^ x;
          2: d[0][8*20 +: 8] = d[0][8*20 +: 8] ^ x;
          3: d[0][8*21 +: 8] = d[0][8*21 +: 8] ^ x;
          default: d[1][8*(f+2) +: 8] = d[1][8*(f+2) +: 8] ^ x;
        endcase
      end
      for (int k = 0; k < n; k++)
        pkt.push_back('{data: d[k], strb: $urandom,
                        user: {$urandom, $urandom, $urandom, $urandom}, last: k == n - 1});
      send_pkt(pkt, model_match(pkt));
    end
    drain("random", 70, 60);
    check_queues("random");
  endtask

  initial begin
    vecs[0] = '{"arp_req",        B0_ARP,   B1_ARP,  2, 1'b1};
    vecs[1] = '{"ip_last_byte",   B0_ARP,   B1_IP65, 2, 1'b0};
    vecs[2] = '{"ip_first_byte",  B0_ARP,   B1_IP00, 2, 1'b0};
    vecs[3] = '{"ethertype_ipv4", B0_IPV4,  B1_ARP,  4, 1'b0};
    vecs[4] = '{"ethertype_swap", B0_SWAP,  B1_ARP,  2, 1'b0};
    vecs[5] = '{"arp_reply",      B0_REPLY, B1_ARP,  2, 1'b0};
    vecs[6] = '{"opcode_hi_byte", B0_OPHI,  B1_ARP,  2, 1'b0};
    vecs[7] = '{"single_beat",    B0_ARP,   B1_ARP,  1, 1'b0};
    vecs[8] = '{"arp_req_long",   B0_ARP,   B1_ARP,  5, 1'b1};

    reset_phase();
    hand_arp_latency();
    hand_single_beat();
    table_phase();
    back_to_back();
    hand_stall();
    hand_reset_in_hold();
    random_phase();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
